shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 101 ++++++++++
 tb/tb_shift_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage 32-bit barrel shifter with valid/ready handshakes.
// Stage 1 applies the 16/8-bit steps, stage 2 the 4/2/1-bit steps.
// Optional macro SHIFT_PIPE_SRL_EN enables logical right shift on op 2'b10;
// without it op 2'b10 is a pass-through and no SRL logic is built.
module shift_pipe (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_operand,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic [1:0]  ctrl_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_result
);

    typedef enum logic [1:0] {
        OpSll  = 2'b00,
        OpSra  = 2'b01,
        OpSrl  = 2'b10,
        OpPass = 2'b11
    } op_e;

    // One power-of-two step; each step applies the op's own fill rule, so a
    // chain of steps equals a single shift by the summed distance.
    function automatic logic [31:0] shift_step(input logic [1:0] op, input logic [31:0] x,
                                               input logic [4:0] k);
        logic [31:0] r;
        case (op)
            OpSll:   r = x << k;
            OpSra:   r = $unsigned($signed(x) >>> k);
`ifdef SHIFT_PIPE_SRL_EN
            OpSrl:   r = x >> k;
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    logic        s1_valid;
    logic [31:0] s1_data;
    logic [2:0]  s1_amt;
    logic [1:0]  s1_op;
    logic [31:0] s1_shift;
    logic [31:0] s2_shift;
    logic        s1_load;
    logic        s2_load;

    // Load enables: stage 2 moves when its slot is free or being drained,
    // stage 1 when empty or when stage 2 takes its contents on this edge.
    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // Stage 1 coarse steps driven by the upper amount bits.
    always_comb begin
        s1_shift = data_operand;
        if (ctrl_shiftamt[4]) s1_shift = shift_step(ctrl_op, s1_shift, 5'd16);
        if (ctrl_shiftamt[3]) s1_shift = shift_step(ctrl_op, s1_shift, 5'd8);
    end

    // Stage 2 fine steps driven by the stored low amount bits.
    always_comb begin
        s2_shift = s1_data;
        if (s1_amt[2]) s2_shift = shift_step(s1_op, s2_shift, 5'd4);
        if (s1_amt[1]) s2_shift = shift_step(s1_op, s2_shift, 5'd2);
        if (s1_amt[0]) s2_shift = shift_step(s1_op, s2_shift, 5'd1);
    end

    // Stage 1 register: partial result, remaining amount, op and valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= 32'h0;
            s1_amt   <= 3'h0;
            s1_op    <= 2'h0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= s1_shift;
                s1_amt  <= ctrl_shiftamt[2:0];
                s1_op   <= ctrl_op;
            end
        end
    end

    // Stage 2 register: final result held stable while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            data_result <= 32'h0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) data_result <= s2_shift;
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed-vector and randomized bench for shift_pipe.
module tb_shift_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic [1:0]  ctrl_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;

    int checks = 0;
    int errors = 0;

    shift_pipe dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operand (data_operand),
        .ctrl_shiftamt(ctrl_shiftamt),
        .ctrl_op      (ctrl_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_result  (data_result)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] SrlExp =
`ifdef SHIFT_PIPE_SRL_EN
        32'h08000000;
`else
        32'h80000000;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bitwise reference: independent of the step decomposition in the design.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                              input logic [31:0] d);
        logic [31:0] r;
        int a;
        a = int'(amt);
        r = d;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00: r[i] = (i >= a) ? d[i-a] : 1'b0;
                2'b01: r[i] = (i + a <= 31) ? d[i+a] : d[31];
`ifdef SHIFT_PIPE_SRL_EN
                2'b10: r[i] = (i + a <= 31) ? d[i+a] : 1'b0;
`endif
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    // Called just after a rising edge; offers one request with out_ready high
    // and checks the result appears after the edge following acceptance.
    task automatic run_one(input string name, input vec_t v);
        in_valid      = 1'b1;
        ctrl_op       = v.op;
        ctrl_shiftamt = v.amt;
        data_operand  = v.d;
        out_ready     = 1'b1;
        #1;
        check({name, "_in_ready"}, {31'b0, in_ready}, 32'h1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check({name, "_lat1_out_valid"}, {31'b0, out_valid}, 32'h0);
        @(posedge clock); #1;
        check({name, "_out_valid"}, {31'b0, out_valid}, 32'h1);
        check({name, "_data"}, data_result, v.exp);
    endtask

    task automatic offer(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d);
        in_valid      = 1'b1;
        ctrl_op       = op;
        ctrl_shiftamt = amt;
        data_operand  = d;
    endtask

    logic [31:0] q[$];

    initial begin
        vecs[0]  = '{2'b01, 5'd16, 32'h80000000, 32'hFFFF8000};
        vecs[1]  = '{2'b00, 5'd31, 32'h00000001, 32'h80000000};
        vecs[2]  = '{2'b00, 5'd0,  32'h12345678, 32'h12345678};
        vecs[3]  = '{2'b01, 5'd0,  32'h12345678, 32'h12345678};
        vecs[4]  = '{2'b10, 5'd0,  32'h12345678, 32'h12345678};
        vecs[5]  = '{2'b11, 5'd0,  32'h12345678, 32'h12345678};
        vecs[6]  = '{2'b10, 5'd4,  32'h80000000, SrlExp};
        vecs[7]  = '{2'b01, 5'd4,  32'hF0000000, 32'hFF000000};
        vecs[8]  = '{2'b00, 5'd4,  32'h12345678, 32'h23456780};
        vecs[9]  = '{2'b11, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[10] = '{2'b01, 5'd31, 32'h80000001, 32'hFFFFFFFF};
        vecs[11] = '{2'b01, 5'd13, 32'h7FFFFFFF, 32'h0003FFFF};

        reset         = 1'b1;
        in_valid      = 1'b0;
        data_operand  = 32'h0;
        ctrl_shiftamt = 5'd0;
        ctrl_op       = 2'b00;
        out_ready     = 1'b0;
        #2;
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_data", data_result, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b0;

        // First request right after reset release, then the directed table.
        for (int i = 0; i < 12; i++) run_one($sformatf("vec%0d", i), vecs[i]);

        // Drain, then fill both stages with out_ready low.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        offer(2'b00, 5'd1, 32'h10);
        #1 check("bp_ready0", {31'b0, in_ready}, 32'h1);
        @(posedge clock); #1;
        offer(2'b00, 5'd2, 32'h10);
        check("bp_ready1", {31'b0, in_ready}, 32'h1);
        @(posedge clock); #1;
        offer(2'b00, 5'd3, 32'h10);
        check("bp_ready_full", {31'b0, in_ready}, 32'h0);
        check("bp_first_valid", {31'b0, out_valid}, 32'h1);
        check("bp_first_data", data_result, 32'h20);
        @(posedge clock); #1;
        check("bp_hold_ready", {31'b0, in_ready}, 32'h0);
        check("bp_hold_data", data_result, 32'h20);
        out_ready = 1'b1;
        #1 check("bp_release_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bp_second_valid", {31'b0, out_valid}, 32'h1);
        check("bp_second_data", data_result, 32'h40);
        @(posedge clock); #1;
        check("bp_third_valid", {31'b0, out_valid}, 32'h1);
        check("bp_third_data", data_result, 32'h80);
        @(posedge clock); #1;
        check("bp_empty", {31'b0, out_valid}, 32'h0);

        // Two requests in flight, then an asynchronous reset mid-cycle.
        out_ready = 1'b0;
        offer(2'b00, 5'd1, 32'h1);
        @(posedge clock); #1;
        offer(2'b00, 5'd2, 32'h1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_in_ready", {31'b0, in_ready}, 32'h1);
        check("arst_data", data_result, 32'h0);
        @(posedge clock); #1;
        check("arst_edge_out_valid", {31'b0, out_valid}, 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("arst_no_stale", {31'b0, out_valid}, 32'h0);
        end

        // Randomized traffic with stalls against the reference model.
        begin
            int          accepted;
            int          cycles;
            logic        fire_in;
            logic        prev_stall;
            logic [31:0] prev_data;
            accepted   = 0;
            cycles     = 0;
            fire_in    = 1'b1;
            prev_stall = 1'b0;
            prev_data  = 32'h0;
            in_valid   = 1'b0;
            while ((accepted < 10000 || q.size() != 0 || out_valid) && cycles < 60000) begin
                if (prev_stall) check("stall_hold", data_result, prev_data);
                if (fire_in || !in_valid) begin
                    in_valid      = (accepted < 10000) && ($urandom_range(0, 3) != 0);
                    ctrl_op       = 2'($urandom_range(0, 3));
                    ctrl_shiftamt = 5'($urandom_range(0, 31));
                    data_operand  = $urandom;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                #4;
                fire_in = in_valid && in_ready;
                if (fire_in) begin
                    q.push_back(ref_shift(ctrl_op, ctrl_shiftamt, data_operand));
                    accepted++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_spurious: got %h expected no output", data_result);
                    end else begin
                        check("rand_result", data_result, q.pop_front());
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = data_result;
                @(posedge clock); #1;
                cycles++;
            end
            in_valid = 1'b0;
            check("rand_accepted", 32'(accepted), 32'd10000);
            check("rand_queue_empty", 32'(q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
